// File: rtl/sram_req_scheduler.sv
// Round-robin scheduler of two writers and two credit-limited readers onto one SRAM port.
// Optional per-port acceptance counters are enabled with `define SRAM_SCHED_STATS_EN.
module sram_req_scheduler #(
  parameter int TAG_DEPTH = 8,
  parameter int CREDITS   = 16
) (
  input  logic        sram_clock,
  input  logic        reset,
  input  logic        w0_valid,
  output logic        w0_ready,
  input  logic [53:0] w0_req,
  input  logic        w1_valid,
  output logic        w1_ready,
  input  logic [53:0] w1_req,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [17:0] r0_addr,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [17:0] r1_addr,
  input  logic        r0_credit,
  input  logic        r1_credit,
  output logic        sram_addr_valid,
  input  logic        sram_ready,
  output logic [17:0] sram_addr,
  output logic [31:0] sram_data_in,
  output logic [3:0]  sram_write_mask,
  input  logic [31:0] sram_data_out,
  input  logic        sram_data_out_valid,
  output logic        r0_data_wr_en,
  output logic        r1_data_wr_en,
  output logic [31:0] rd_data,
  output logic        err_underflow,
  output logic        err_credit
`ifdef SRAM_SCHED_STATS_EN
  ,
  output logic [15:0] stat_w0,
  output logic [15:0] stat_w1,
  output logic [15:0] stat_r0,
  output logic [15:0] stat_r1
`endif
);

  localparam int TW = $clog2(TAG_DEPTH);
  localparam logic [TW:0] TAG_FULL = (TW+1)'(TAG_DEPTH);
  localparam logic [5:0]  CRED_MAX = 6'(CREDITS);

  logic              cmdValid_q;
  logic [17:0]       cmdAddr_q;
  logic [31:0]       cmdData_q;
  logic [3:0]        cmdMask_q;
  logic [1:0]        lastGrant_q;
  logic [5:0]        cred0_q, cred1_q;
  logic [TW:0]       tagCount_q;
  logic [TW-1:0]     tagWr_q, tagRd_q;
  logic [TAG_DEPTH-1:0] tagMem_q;
  logic              errUnder_q, errCredit_q;

  logic [3:0]  elig;
  logic        grantHit, canLoad, accept;
  logic [1:0]  grantIdx, scanIdx;
  logic [17:0] selAddr;
  logic [31:0] selData;
  logic [3:0]  selMask;
  logic        tagPush, tagPop, headId;
  logic        take0, take1;

  assign elig[0] = w0_valid;
  assign elig[1] = w1_valid;
  assign elig[2] = r0_valid && (cred0_q != 6'd0) && (tagCount_q < TAG_FULL);
  assign elig[3] = r1_valid && (cred1_q != 6'd0) && (tagCount_q < TAG_FULL);

  // Scan starts just after the last winner, so the last winner is checked last.
  always_comb begin
    grantHit = 1'b0;
    grantIdx = 2'd0;
    scanIdx  = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      scanIdx = lastGrant_q + 2'(k);
      if (!grantHit && elig[scanIdx]) begin
        grantHit = 1'b1;
        grantIdx = scanIdx;
      end
    end
  end

  assign canLoad = !cmdValid_q || sram_ready;
  assign accept  = grantHit && canLoad && !reset;

  assign w0_ready = accept && (grantIdx == 2'd0);
  assign w1_ready = accept && (grantIdx == 2'd1);
  assign r0_ready = accept && (grantIdx == 2'd2);
  assign r1_ready = accept && (grantIdx == 2'd3);

  always_comb begin
    selAddr = r1_addr;
    selData = 32'd0;
    selMask = 4'd0;
    case (grantIdx)
      2'd0: begin selAddr = w0_req[49:32]; selData = w0_req[31:0]; selMask = w0_req[53:50]; end
      2'd1: begin selAddr = w1_req[49:32]; selData = w1_req[31:0]; selMask = w1_req[53:50]; end
      2'd2: selAddr = r0_addr;
      default: selAddr = r1_addr;
    endcase
  end

  assign take0   = r0_ready;
  assign take1   = r1_ready;
  assign tagPush = take0 || take1;
  assign tagPop  = sram_data_out_valid && (tagCount_q != '0) && !reset;
  assign headId  = tagMem_q[tagRd_q];

  assign r0_data_wr_en   = tagPop && !headId;
  assign r1_data_wr_en   = tagPop && headId;
  assign rd_data         = sram_data_out;
  assign sram_addr_valid = cmdValid_q;
  assign sram_addr       = cmdAddr_q;
  assign sram_data_in    = cmdData_q;
  assign sram_write_mask = cmdMask_q;
  assign err_underflow   = errUnder_q;
  assign err_credit      = errCredit_q;

  always_ff @(posedge sram_clock) begin
    if (reset) begin
      cmdValid_q  <= 1'b0;
      cmdAddr_q   <= '0;
      cmdData_q   <= '0;
      cmdMask_q   <= '0;
      lastGrant_q <= 2'd3;
      cred0_q     <= CRED_MAX;
      cred1_q     <= CRED_MAX;
      tagCount_q  <= '0;
      tagWr_q     <= '0;
      tagRd_q     <= '0;
      errUnder_q  <= 1'b0;
      errCredit_q <= 1'b0;
    end else begin
      if (accept) begin
        cmdValid_q  <= 1'b1;
        cmdAddr_q   <= selAddr;
        cmdData_q   <= selData;
        cmdMask_q   <= selMask;
        lastGrant_q <= grantIdx;
      end else if (sram_ready) begin
        cmdValid_q <= 1'b0;
      end

      if (tagPush) begin
        tagMem_q[tagWr_q] <= take1;
        tagWr_q <= tagWr_q + (TW)'(1);
      end
      if (tagPop) tagRd_q <= tagRd_q + (TW)'(1);
      if (tagPush && !tagPop) tagCount_q <= tagCount_q + (TW+1)'(1);
      else if (!tagPush && tagPop) tagCount_q <= tagCount_q - (TW+1)'(1);

      // A credit pulse at full credit is dropped and flagged; accept+pulse cancel out.
      if (take0 && !r0_credit) cred0_q <= cred0_q - 6'd1;
      else if (!take0 && r0_credit && cred0_q != CRED_MAX) cred0_q <= cred0_q + 6'd1;
      if (take1 && !r1_credit) cred1_q <= cred1_q - 6'd1;
      else if (!take1 && r1_credit && cred1_q != CRED_MAX) cred1_q <= cred1_q + 6'd1;

      if ((!take0 && r0_credit && cred0_q == CRED_MAX) ||
          (!take1 && r1_credit && cred1_q == CRED_MAX)) errCredit_q <= 1'b1;
      if (sram_data_out_valid && tagCount_q == '0) errUnder_q <= 1'b1;
    end
  end

`ifdef SRAM_SCHED_STATS_EN
  logic [15:0] statW0_q, statW1_q, statR0_q, statR1_q;

  always_ff @(posedge sram_clock) begin
    if (reset) begin
      statW0_q <= '0;
      statW1_q <= '0;
      statR0_q <= '0;
      statR1_q <= '0;
    end else begin
      if (w0_ready && statW0_q != 16'hFFFF) statW0_q <= statW0_q + 16'd1;
      if (w1_ready && statW1_q != 16'hFFFF) statW1_q <= statW1_q + 16'd1;
      if (r0_ready && statR0_q != 16'hFFFF) statR0_q <= statR0_q + 16'd1;
      if (r1_ready && statR1_q != 16'hFFFF) statR1_q <= statR1_q + 16'd1;
    end
  end

  assign stat_w0 = statW0_q;
  assign stat_w1 = statW1_q;
  assign stat_r0 = statR0_q;
  assign stat_r1 = statR1_q;
`endif

endmodule
